// File: rtl/nmc_job_scheduler.sv
// rtl/nmc_job_scheduler.sv - queued kernel-launch dispatcher for one near-memory accelerator
// Optional perf counters (perf_jobs_o, perf_busy_cycles_o) when NMC_SCHED_PERF_CNT_EN is defined.
module nmc_job_scheduler #(
   parameter int QueueDepth = 4,
   parameter int IdWidth    = 4,
   parameter int CntWidth   = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                job_valid_i,
   output logic                job_ready_o,
   input  logic [31:0]         job_pc_i,
   input  logic [IdWidth-1:0]  job_id_i,
   input  logic [CntWidth-1:0] timeout_cycles_i,
   input  logic                abort_i,
   output logic [31:0]         nmc_boot_pc_o,
   output logic                nmc_fetch_en_o,
   output logic                nmc_start_o,
   input  logic                nmc_done_i,
   output logic                cpl_valid_o,
   input  logic                cpl_ready_i,
   output logic [IdWidth-1:0]  cpl_id_o,
   output logic [1:0]          cpl_status_o,
   output logic [CntWidth-1:0] cpl_cycles_o,
   output logic                busy_o,
   output logic                irq_o
`ifdef NMC_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]         perf_jobs_o,
   output logic [31:0]         perf_busy_cycles_o
`endif
);

   localparam int PtrW  = $clog2(QueueDepth);
   localparam int CntQW = PtrW + 1;
   localparam logic [CntQW-1:0] QFull = CntQW'(QueueDepth);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

   state_t              state;
   logic [31:0]         q_pc [QueueDepth];
   logic [IdWidth-1:0]  q_id [QueueDepth];
   logic [PtrW-1:0]     wr_ptr;
   logic [PtrW-1:0]     rd_ptr;
   logic [CntQW-1:0]    q_count;
   logic [CntQW-1:0]    q_count_nxt;
   logic [IdWidth-1:0]  cur_id;
   logic [CntWidth-1:0] run_cnt;
   logic                push;
   logic                pop;
   logic                run_end;

   // abort wins over both queue operations: a simultaneous push is dropped
   assign push = job_valid_i && job_ready_o && !abort_i;
   assign pop  = (state == IDLE) && (q_count != '0) && !abort_i;

   assign run_end = nmc_done_i || abort_i ||
                    ((timeout_cycles_i != '0) && (run_cnt == timeout_cycles_i));

   assign busy_o = (state != IDLE) || (q_count != '0);

   always_comb begin
      q_count_nxt = q_count;
      if (abort_i)
         q_count_nxt = '0;
      else if (push && !pop)
         q_count_nxt = q_count + 1'b1;
      else if (!push && pop)
         q_count_nxt = q_count - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_pc[wr_ptr] <= job_pc_i;
         q_id[wr_ptr] <= job_id_i;
      end
   end

   // ready is registered from the next occupancy so it stays 0 while in reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         q_count     <= '0;
         job_ready_o <= 1'b0;
      end else begin
         q_count     <= q_count_nxt;
         job_ready_o <= (q_count_nxt != QFull);
         if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state          <= IDLE;
         cur_id         <= '0;
         run_cnt        <= '0;
         nmc_boot_pc_o  <= '0;
         nmc_fetch_en_o <= 1'b0;
         nmc_start_o    <= 1'b0;
         cpl_valid_o    <= 1'b0;
         cpl_id_o       <= '0;
         cpl_status_o   <= ST_OK;
         cpl_cycles_o   <= '0;
         irq_o          <= 1'b0;
      end else begin
         nmc_start_o <= 1'b0;
         irq_o       <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  nmc_boot_pc_o  <= q_pc[rd_ptr];
                  cur_id         <= q_id[rd_ptr];
                  nmc_fetch_en_o <= 1'b1;
                  nmc_start_o    <= 1'b1;
                  state          <= LAUNCH;
               end
            end
            LAUNCH: begin
               run_cnt <= CntWidth'(1);
               state   <= RUN;
            end
            RUN: begin
               if (run_end) begin
                  nmc_fetch_en_o <= 1'b0;
                  cpl_valid_o    <= 1'b1;
                  irq_o          <= 1'b1;
                  cpl_id_o       <= cur_id;
                  cpl_cycles_o   <= run_cnt;
                  cpl_status_o   <= nmc_done_i ? ST_OK : (abort_i ? ST_ABORT : ST_TIMEOUT);
                  state          <= RESP;
               end else if (run_cnt != '1) begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            RESP: begin
               if (cpl_ready_i) begin
                  cpl_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef NMC_SCHED_PERF_CNT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_jobs_o        <= '0;
         perf_busy_cycles_o <= '0;
      end else begin
         if (cpl_valid_o && cpl_ready_i)
            perf_jobs_o <= perf_jobs_o + 1'b1;
         if ((state == LAUNCH) || (state == RUN))
            perf_busy_cycles_o <= perf_busy_cycles_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nmc_job_scheduler.sv
// tb/tb_nmc_job_scheduler.sv - scoreboard bench for nmc_job_scheduler
module tb_nmc_job_scheduler;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        job_valid;
   logic        job_ready_o;
   logic [31:0] job_pc;
   logic [3:0]  job_id;
   logic [31:0] timeout_cycles;
   logic        abort;
   logic [31:0] nmc_boot_pc_o;
   logic        nmc_fetch_en_o;
   logic        nmc_start_o;
   logic        nmc_done;
   logic        cpl_valid_o;
   logic        cpl_ready;
   logic [3:0]  cpl_id_o;
   logic [1:0]  cpl_status_o;
   logic [31:0] cpl_cycles_o;
   logic        busy_o;
   logic        irq_o;
`ifdef NMC_SCHED_PERF_CNT_EN
   logic [31:0] perf_jobs_o;
   logic [31:0] perf_busy_cycles_o;
`endif

   always #5 clk = ~clk;

   nmc_job_scheduler dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .job_valid_i      (job_valid),
      .job_ready_o      (job_ready_o),
      .job_pc_i         (job_pc),
      .job_id_i         (job_id),
      .timeout_cycles_i (timeout_cycles),
      .abort_i          (abort),
      .nmc_boot_pc_o    (nmc_boot_pc_o),
      .nmc_fetch_en_o   (nmc_fetch_en_o),
      .nmc_start_o      (nmc_start_o),
      .nmc_done_i       (nmc_done),
      .cpl_valid_o      (cpl_valid_o),
      .cpl_ready_i      (cpl_ready),
      .cpl_id_o         (cpl_id_o),
      .cpl_status_o     (cpl_status_o),
      .cpl_cycles_o     (cpl_cycles_o),
      .busy_o           (busy_o),
      .irq_o            (irq_o)
`ifdef NMC_SCHED_PERF_CNT_EN
      ,
      .perf_jobs_o        (perf_jobs_o),
      .perf_busy_cycles_o (perf_busy_cycles_o)
`endif
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [1:0]  st;
      logic [31:0] cyc;
   } rec_t;

   rec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_cpl    = 0;
   int   n_irq    = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // completion monitor: scoreboard pop on handshake, irq must mark the rising edge of cpl_valid
   always @(negedge clk) begin
      rec_t e;
      if (rst_ni) begin
         if (irq_o || cpl_valid_o)
            check("irq_pulse", 64'(irq_o), 64'(cpl_valid_o && !prev_valid));
         if (irq_o) n_irq++;
         if (cpl_valid_o && cpl_ready) begin
            n_cpl++;
            if (sb.size() == 0) begin
               check("sb_unexpected_cpl", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               check("cpl_id", 64'(cpl_id_o), 64'(e.id));
               check("cpl_status", 64'(cpl_status_o), 64'(e.st));
               check("cpl_cycles", 64'(cpl_cycles_o), 64'(e.cyc));
            end
         end
      end
      prev_valid = cpl_valid_o;
   end

   task automatic push_job(input logic [31:0] pc, input logic [3:0] id, input bit exp_cpl,
                           input logic [1:0] st, input logic [31:0] cyc, output int waited);
      bit acc = 0;
      waited    = 0;
      job_valid = 1'b1;
      job_pc    = pc;
      job_id    = id;
      while (!acc && waited < 200) begin
         @(negedge clk);
         acc = job_ready_o;
         step();
         if (!acc) waited++;
      end
      job_valid = 1'b0;
      if (!acc)
         check("push_accept_timeout", 64'(acc), 64'd1);
      else if (exp_cpl)
         sb.push_back('{id: id, st: st, cyc: cyc});
   endtask

   task automatic wait_start();
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = nmc_start_o;
         step();
      end
      check("wait_start", 64'(seen), 64'd1);
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int i = 0; i < 400 && !idle; i++) begin
         @(negedge clk);
         idle = !busy_o && !cpl_valid_o;
         step();
      end
      check("wait_idle", 64'(idle), 64'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_boot_pc"}, 64'(nmc_boot_pc_o), 64'd0);
      check({tag, "_cycles"}, 64'(cpl_cycles_o), 64'd0);
      check({tag, "_ctrl"}, 64'({job_ready_o, nmc_fetch_en_o, nmc_start_o, cpl_valid_o,
                                 cpl_id_o, cpl_status_o, busy_o, irq_o}), 64'd0);
   endtask

   initial begin
      int w;
      rst_ni = 1'b0; job_valid = 1'b0; job_pc = '0; job_id = '0;
      timeout_cycles = '0; abort = 1'b0; nmc_done = 1'b0; cpl_ready = 1'b1;
      step(); step();
      @(negedge clk);
      check_outputs_zero("reset");
      rst_ni = 1'b1;
      step();
      @(negedge clk);
      check("ready_after_reset", 64'(job_ready_o), 64'd1);
      step();

      // single job, done on 10th RUN cycle, done during LAUNCH ignored
      n_irq = 0;
      push_job(32'h0000_2000, 4'd3, 1, ST_OK, 32'd10, w);
      @(negedge clk);
      check("start_not_early", 64'(nmc_start_o), 64'd0);
      step();
      nmc_done = 1'b1;
      @(negedge clk);
      check("start_latency", 64'(nmc_start_o), 64'd1);
      check("launch_fetch_en", 64'(nmc_fetch_en_o), 64'd1);
      check("launch_boot_pc", 64'(nmc_boot_pc_o), 64'h2000);
      step();
      nmc_done = 1'b0;
      @(negedge clk);
      check("run_fetch_en", 64'(nmc_fetch_en_o), 64'd1);
      check("run_start_low", 64'(nmc_start_o), 64'd0);
      step();
      repeat (8) step();
      nmc_done = 1'b1;
      step();
      nmc_done = 1'b0;
      wait_idle();
      check("irq_once", 64'(n_irq), 64'd1);

      // queue fill while blocked in RUN; every job times out at 12
      timeout_cycles = 32'd12;
      push_job(32'h0000_1000, 4'd15, 1, ST_TIMEOUT, 32'd12, w);
      wait_start();
      for (int i = 0; i < 4; i++)
         push_job(32'h0000_4000 + 32'(i * 16), 4'(i), 1, ST_TIMEOUT, 32'd12, w);
      @(negedge clk);
      check("queue_full_ready", 64'(job_ready_o), 64'd0);
      check("queue_full_busy", 64'(busy_o), 64'd1);
      step();
      push_job(32'h0000_4040, 4'd4, 1, ST_TIMEOUT, 32'd12, w);
      check("fifth_held", 64'(w != 0), 64'd1);
      wait_idle();

      // timeout 20 with 7 cycles of completion back-pressure
      timeout_cycles = 32'd20;
      cpl_ready = 1'b0;
      push_job(32'h0000_5000, 4'd5, 1, ST_TIMEOUT, 32'd20, w);
      push_job(32'h0000_3000, 4'd6, 1, ST_OK, 32'd3, w);
      begin
         bit seen = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = cpl_valid_o;
            if (!seen) step();
         end
         check("resp_reached", 64'(seen), 64'd1);
      end
      for (int i = 0; i < 7; i++) begin
         check("hold_valid", 64'(cpl_valid_o), 64'd1);
         check("hold_fields", 64'({cpl_id_o, cpl_status_o, cpl_cycles_o}), 64'({4'd5, ST_TIMEOUT, 32'd20}));
         check("hold_fetch_en", 64'(nmc_fetch_en_o), 64'd0);
         check("hold_no_start", 64'(nmc_start_o), 64'd0);
         step();
         if (i < 6) @(negedge clk);
      end
      cpl_ready = 1'b1;
      step();
      @(negedge clk);
      check("idle_no_start", 64'(nmc_start_o), 64'd0);
      step();
      @(negedge clk);
      check("next_start", 64'(nmc_start_o), 64'd1);
      check("next_boot_pc", 64'(nmc_boot_pc_o), 64'h3000);
      step();
      repeat (2) step();
      nmc_done = 1'b1;
      step();
      nmc_done = 1'b0;
      wait_idle();

      // done, abort and timeout in the same RUN cycle; queued job is flushed
      timeout_cycles = 32'd6;
      push_job(32'h0000_6000, 4'd7, 1, ST_OK, 32'd6, w);
      push_job(32'h0000_7000, 4'd8, 0, ST_OK, 32'd0, w);
      wait_start();
      repeat (5) step();
      nmc_done = 1'b1;
      abort = 1'b1;
      step();
      nmc_done = 1'b0;
      abort = 1'b0;
      wait_idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("flushed_no_start", 64'({nmc_start_o, busy_o}), 64'd0);
         step();
      end

`ifdef NMC_SCHED_PERF_CNT_EN
      check("perf_jobs", 64'(perf_jobs_o), 64'(n_cpl));
      check("perf_busy_nonzero", 64'(perf_busy_cycles_o != 0), 64'd1);
`endif

      // reset mid-RUN with three queued jobs; later done pulse ignored
      timeout_cycles = 32'd0;
      push_job(32'h0000_8000, 4'd9, 0, ST_OK, 32'd0, w);
      push_job(32'h0000_8100, 4'd10, 0, ST_OK, 32'd0, w);
      push_job(32'h0000_8200, 4'd11, 0, ST_OK, 32'd0, w);
      push_job(32'h0000_8300, 4'd12, 0, ST_OK, 32'd0, w);
      step(); step();
      @(negedge clk);
      check("pre_reset_running", 64'({nmc_fetch_en_o, busy_o}), 64'b11);
      step();
      rst_ni = 1'b0;
      step();
      @(negedge clk);
      check_outputs_zero("midrun_reset");
`ifdef NMC_SCHED_PERF_CNT_EN
      check("perf_jobs_reset", 64'(perf_jobs_o), 64'd0);
      check("perf_busy_reset", 64'(perf_busy_cycles_o), 64'd0);
`endif
      rst_ni = 1'b1;
      step();
      nmc_done = 1'b1;
      step();
      nmc_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_reset_quiet", 64'({cpl_valid_o, nmc_start_o, nmc_fetch_en_o, busy_o, job_ready_o}),
               64'b00001);
         step();
      end

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/nmc_job_scheduler.md
Name: nmc_job_scheduler

Overview:
- Hardware dispatcher that sequences kernel launches on one near-memory-computing accelerator (NM-Carus class).
- Buffers job descriptors (boot PC + ID) from the host bus in a small queue and programs boot PC / fetch enable one job at a time.
- Waits for the accelerator's done pulse, measures execution cycles, applies a watchdog timeout, and returns one completion record per job.
- Sits between the system bus peripheral registers and the accelerator configuration interface.

Parameters:
QueueDepth, 4, job queue entries; power of two, >=2
IdWidth, 4, job ID width
CntWidth, 32, cycle counter / timeout width

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  queue can accept a descriptor
job_pc_i  in  32  kernel boot PC
job_id_i  in  IdWidth  job tag
timeout_cycles_i  in  CntWidth  watchdog limit; 0 disables the watchdog
abort_i  in  1  abort in-flight job and flush the queue
nmc_boot_pc_o  out  32  boot PC to accelerator
nmc_fetch_en_o  out  1  accelerator fetch enable
nmc_start_o  out  1  one-cycle start pulse
nmc_done_i  in  1  one-cycle done pulse from accelerator
cpl_valid_o  out  1  completion record valid
cpl_ready_i  in  1  completion consumed
cpl_id_o  out  IdWidth  completed job ID
cpl_status_o  out  2  00 OK, 01 TIMEOUT, 10 ABORT
cpl_cycles_o  out  CntWidth  RUN cycles of completed job
busy_o  out  1  FSM not IDLE or queue non-empty
irq_o  out  1  one-cycle pulse when cpl_valid_o rises

Behaviour:
- Reset: sampled on clk_i rising edge with rst_ni=0.
  - All outputs 0; queue empty; FSM IDLE.
  - job_ready_o is 1 from the first cycle after reset.
- Queue: FIFO with wrapping pointers and an occupancy count.
  - job_ready_o = !full; it does not depend on a same-cycle dequeue.
  - Push when job_valid_i && job_ready_o.
  - Simultaneous push and pop on a non-full queue keeps the count unchanged.
- FSM states:
  - IDLE: if queue non-empty, pop head, latch pc/id, go to LAUNCH.
  - LAUNCH (1 cycle): nmc_boot_pc_o = latched pc, nmc_fetch_en_o = 1, nmc_start_o = 1. Go to RUN.
  - RUN:
    - nmc_fetch_en_o = 1, nmc_boot_pc_o held.
    - cnt starts at 1 in the first RUN cycle and increments each cycle, saturating at all-ones.
    - nmc_done_i=1: cycles = cnt, status OK, go to RESP.
    - Else abort_i=1: status ABORT, go to RESP.
    - Else timeout_cycles_i != 0 and cnt == timeout_cycles_i: status TIMEOUT, go to RESP.
    - Priority: done > abort > timeout.
  - RESP:
    - nmc_fetch_en_o = 0; cpl_valid_o = 1, with id/status/cycles stable until accepted.
    - On cpl_valid_o && cpl_ready_i, go to IDLE. A new job launches no earlier than the cycle after IDLE.
- irq_o: pulses in the first RESP cycle only.
- nmc_done_i outside RUN is ignored, including a pulse in the LAUNCH cycle.
- abort_i flushes every queued entry in the same cycle (count := 0), in any state.
  - It overrides a simultaneous push: the pushed job is dropped.
  - In IDLE or RESP it does not touch the current completion record.
- Latency: job pushed into an empty queue while IDLE → nmc_start_o exactly 2 cycles later (cycle 0 push, cycle 1 IDLE pop, cycle 2 LAUNCH).
- busy_o = (state != IDLE) || count != 0.

Optional Feature:
NMC_SCHED_PERF_CNT_EN
- Defined: adds outputs perf_jobs_o[31:0] (completions accepted, any status) and perf_busy_cycles_o[31:0] (cycles spent in LAUNCH+RUN).
  - Both are wrapping counters, reset to 0 by rst_ni only; abort_i does not clear them.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Push pc=0x0000_2000 id=3 with timeout=0; done pulse on the 10th RUN cycle → nmc_start_o 2 cycles after push, fetch_en=1, cpl id=3 status=00 cycles=10, irq_o pulses once.
- Push 5 jobs back-to-back with QueueDepth=4 while the FSM is blocked in RUN → job_ready_o=0 after the 4th accepted push; the 5th is held until a pop; completions come out in push order with IDs 0..4.
- timeout=20, done never arrives → status=01 cycles=20, fetch_en drops in RESP; next queued job launches after cpl_ready_i.
- In the same RUN cycle, done, abort and cnt==timeout all fire → status=00; abort still flushes the queue (busy_o=0 after accept).
- Hold cpl_ready_i=0 for 7 cycles in RESP → cpl fields stable, irq_o high only in the first cycle, no new nmc_start_o until the cycle after IDLE.
- rst_ni=0 mid-RUN with 3 queued → next cycle all outputs 0, queue empty; the done pulse arriving after reset is ignored; with NMC_SCHED_PERF_CNT_EN both perf counters read 0.
